// File: rtl/alu_byte_serial.sv
// Byte-serial 32-bit ALU: one 8-bit slice per BUSY cycle, ripple carry held in a register.
// Handshake: req_valid/req_ready to start, rsp_valid/rsp_ready to retire the result.
module alu_byte_serial (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] operandA,
  input  logic [31:0] operandB,
  input  logic [2:0]  command,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] result,
  output logic        carryout,
  output logic        overflow,
  output logic        zero
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [2:0] CMD_ADD  = 3'b000;
  localparam logic [2:0] CMD_SUB  = 3'b001;
  localparam logic [2:0] CMD_XOR  = 3'b010;
  localparam logic [2:0] CMD_SLT  = 3'b011;
  localparam logic [2:0] CMD_AND  = 3'b100;
  localparam logic [2:0] CMD_NAND = 3'b101;
  localparam logic [2:0] CMD_NOR  = 3'b110;
  localparam logic [2:0] CMD_OR   = 3'b111;

  state_t      state_q, state_d;
  logic [31:0] a_q, b_q;
  logic [2:0]  cmd_q;
  logic [1:0]  idx_q;
  logic        carry_q;

  logic [7:0]  a_byte, b_byte, b_eff, byte_res;
  logic [8:0]  sum9;
  logic        sub_like, c_in31, c_out31, ovf31, slt_bit;
  logic [31:0] result_d;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == DONE);
  assign zero      = (result == 32'd0);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = BUSY;
      BUSY:    if (idx_q == 2'd3) state_d = DONE;
      DONE:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Slice datapath; flags are only meaningful on the last (idx=3) slice.
  always_comb begin
    sub_like = (cmd_q == CMD_SUB) || (cmd_q == CMD_SLT);
    a_byte   = a_q[{idx_q, 3'b000} +: 8];
    b_byte   = b_q[{idx_q, 3'b000} +: 8];
    b_eff    = sub_like ? ~b_byte : b_byte;
    sum9     = {1'b0, a_byte} + {1'b0, b_eff} + {8'd0, carry_q};
    c_in31   = a_byte[7] ^ b_eff[7] ^ sum9[7];
    c_out31  = sum9[8];
    ovf31    = c_in31 ^ c_out31;
    slt_bit  = sum9[7] ^ ovf31;
    byte_res = sum9[7:0];
    case (cmd_q)
      CMD_XOR:  byte_res = a_byte ^ b_byte;
      CMD_AND:  byte_res = a_byte & b_byte;
      CMD_NAND: byte_res = ~(a_byte & b_byte);
      CMD_NOR:  byte_res = ~(a_byte | b_byte);
      CMD_OR:   byte_res = a_byte | b_byte;
      default:  byte_res = sum9[7:0];
    endcase
    result_d = result;
    result_d[{idx_q, 3'b000} +: 8] = byte_res;
    if ((idx_q == 2'd3) && (cmd_q == CMD_SLT)) result_d = {31'd0, slt_bit};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      cmd_q    <= CMD_ADD;
      idx_q    <= 2'd0;
      carry_q  <= 1'b0;
      result   <= 32'd0;
      carryout <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          a_q     <= operandA;
          b_q     <= operandB;
          cmd_q   <= command;
          idx_q   <= 2'd0;
          carry_q <= (command == CMD_SUB) || (command == CMD_SLT);
        end
        BUSY: begin
          result  <= result_d;
          carry_q <= c_out31;
          idx_q   <= idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            if ((cmd_q == CMD_ADD) || (cmd_q == CMD_SUB)) begin
              carryout <= c_out31;
              overflow <= ovf31;
            end else begin
              carryout <= 1'b0;
              overflow <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_byte_serial.sv
// Randomized self-checking bench for alu_byte_serial against a word-level arithmetic model.
module tb_alu_byte_serial;

  logic        clk = 1'b0;
  logic        reset, req_valid, req_ready, rsp_valid, rsp_ready;
  logic [31:0] operandA, operandB, result;
  logic [2:0]  command;
  logic        carryout, overflow, zero;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_byte_serial dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .operandA(operandA), .operandB(operandB), .command(command),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .result(result),
    .carryout(carryout), .overflow(overflow), .zero(zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Word-level reference: returns {overflow, carryout, result}.
  function automatic logic [33:0] model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic co, ov;
    co = 1'b0; ov = 1'b0; r = 32'd0;
    case (c)
      3'b000: begin
        s = {1'b0, a} + {1'b0, b}; r = s[31:0]; co = s[32];
        ov = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'b001: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; co = s[32];
        ov = (a[31] != b[31]) && (r[31] != a[31]);
      end
      3'b010: r = a ^ b;
      3'b011: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b100: r = a & b;
      3'b101: r = ~(a & b);
      3'b110: r = ~(a | b);
      default: r = a | b;
    endcase
    return {ov, co, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge while idle; issues one command and retires it.
  task automatic do_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [33:0] e;
    int lat;
    e = model(c, a, b);
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    command = c; operandA = a; operandB = b; req_valid = 1'b1;
    rsp_ready = 1'($urandom);
    tick();
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 10) begin
      operandA = $urandom; operandB = $urandom; command = 3'($urandom);
      rsp_ready = 1'($urandom);
      tick();
      lat++;
    end
    rsp_ready = 1'b0;
    check("latency", 32'(lat), 32'd4);
    check("result", result, e[31:0]);
    check("carryout", {31'd0, carryout}, {31'd0, e[32]});
    check("overflow", {31'd0, overflow}, {31'd0, e[33]});
    check("zero", {31'd0, zero}, {31'd0, (e[31:0] == 32'd0)});
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'($urandom); operandA = $urandom; operandB = $urandom; command = 3'($urandom);
      tick();
      check("hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_ready", {31'd0, req_ready}, 32'd0);
      check("hold_result", result, e[31:0]);
      check("hold_flags", {30'd0, overflow, carryout}, {30'd0, e[33:32]});
    end
    // Retire with req_valid high: the retiring edge must not also accept.
    req_valid = 1'b1; rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0; rsp_ready = 1'b0;
    check("retire_valid", {31'd0, rsp_valid}, 32'd0);
    check("retire_ready", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    operandA = 32'd0; operandB = 32'd0; command = 3'd0;
    @(negedge clk);
    tick();
    check("rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_result", result, 32'd0);
    check("rst_flags", {29'd0, zero, overflow, carryout}, 32'b100);
    reset = 1'b0;
    tick();

    do_op(3'b000, 32'd2147483647, 32'd14000, 0);
    do_op(3'b001, 32'd3657483652, 32'd3657483652, 1);
    do_op(3'b001, 32'd2147483652, 32'd2147483644, 0);
    do_op(3'b011, 32'd3657483652, 32'd1000, 0);
    do_op(3'b011, 32'd1000, 32'd3657483652, 0);
    do_op(3'b111, 32'd12, 32'd10, 0);
    do_op(3'b110, 32'd12, 32'd10, 0);
    do_op(3'b010, 32'd12, 32'd10, 0);
    do_op(3'b100, 32'd12, 32'd10, 0);
    do_op(3'b101, 32'd12, 32'd10, 0);
    do_op(3'b000, 32'd3657483652, 32'd637483644, 0);
    do_op(3'b001, 32'd5, 32'd7, 10);

    // Reset at the second BUSY cycle, with req_valid and rsp_ready also high.
    command = 3'b000; operandA = 32'hFFFF_FFFF; operandB = 32'd1; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    reset = 1'b1; req_valid = 1'b1; rsp_ready = 1'b1;
    tick();
    reset = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    check("midrst_valid", {31'd0, rsp_valid}, 32'd0);
    check("midrst_ready", {31'd0, req_ready}, 32'd1);
    check("midrst_result", result, 32'd0);
    check("midrst_flags", {29'd0, zero, overflow, carryout}, 32'b100);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("midrst_noresp", {31'd0, rsp_valid}, 32'd0);
    end
    do_op(3'b000, 32'd7000, 32'd14000, 0);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom; rb = $urandom;
      if (i % 8 == 0) rb = ra;
      if (i % 8 == 1) rb = -ra;
      do_op(3'($urandom), ra, rb, int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
